// File: rtl/dataset_sequencer.sv
// Walks the training or testing set one sample at a time, handshaking with the encoder,
// counting correct test predictions and pulsing a finished flag at the end of each pass.
module dataset_sequencer #(
  parameter int unsigned NUM_TRAIN = 64,
  parameter int unsigned NUM_TEST  = 32,
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned CNT_W     = 8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              training_hdc_model,
  input  logic              testing_hdc_model,
  output logic              sample_req,
  output logic [ADDR_W-1:0] sample_addr,
  output logic              sample_is_test,
  input  logic              sample_ack,
  input  logic              sample_done,
  input  logic              pred_correct,
  output logic              training_dataset_finished,
  output logic              testing_dataset_finished,
  output logic [CNT_W-1:0]  correct_count,
  output logic              busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_FIN} state_t;

  localparam logic [ADDR_W-1:0] TRAIN_LAST = ADDR_W'(NUM_TRAIN - 1);
  localparam logic [ADDR_W-1:0] TEST_LAST  = ADDR_W'(NUM_TEST - 1);

  state_t            state;
  logic              phase;  // 0 = train, 1 = test
  logic [ADDR_W-1:0] index;
  logic              mode_active;
  logic              last_idx;

  assign mode_active = phase ? testing_hdc_model : training_hdc_model;
  assign last_idx    = (index == (phase ? TEST_LAST : TRAIN_LAST));
  assign sample_addr = index;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state                     <= S_IDLE;
      phase                     <= 1'b0;
      index                     <= '0;
      sample_req                <= 1'b0;
      sample_is_test            <= 1'b0;
      training_dataset_finished <= 1'b0;
      testing_dataset_finished  <= 1'b0;
      correct_count             <= '0;
      busy                      <= 1'b0;
    end else begin
      training_dataset_finished <= 1'b0;
      testing_dataset_finished  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (training_hdc_model) begin
            phase          <= 1'b0;
            index          <= '0;
            sample_req     <= 1'b1;
            sample_is_test <= 1'b0;
            busy           <= 1'b1;
            state          <= S_REQ;
          end else if (testing_hdc_model) begin
            phase          <= 1'b1;
            index          <= '0;
            correct_count  <= '0;
            sample_req     <= 1'b1;
            sample_is_test <= 1'b1;
            busy           <= 1'b1;
            state          <= S_REQ;
          end
        end
        S_REQ: begin
          if (!mode_active) begin
            sample_req     <= 1'b0;
            sample_is_test <= 1'b0;
            busy           <= 1'b0;
            state          <= S_IDLE;
          end else if (sample_ack) begin
            sample_req <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          // An abort wins over a coincident sample_done.
          if (!mode_active) begin
            sample_is_test <= 1'b0;
            busy           <= 1'b0;
            state          <= S_IDLE;
          end else if (sample_done) begin
            if (phase && pred_correct && (correct_count != '1)) begin
              correct_count <= correct_count + CNT_W'(1);
            end
            if (last_idx) begin
              if (phase) testing_dataset_finished <= 1'b1;
              else       training_dataset_finished <= 1'b1;
              state <= S_FIN;
            end else begin
              index      <= index + ADDR_W'(1);
              sample_req <= 1'b1;
              state      <= S_REQ;
            end
          end
        end
        S_FIN: begin
          // Hold here until the requesting mode drops so the pass cannot retrigger.
          if (!mode_active) begin
            sample_is_test <= 1'b0;
            busy           <= 1'b0;
            state          <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dataset_sequencer.sv
// Randomised bench for dataset_sequencer: a responder plays the encoder and a pass-level
// model predicts address order, finished pulses and the saturated correct count.
module tb_dataset_sequencer;

  localparam int NTR = 4;
  localparam int NTE = 5;

  logic       clk = 1'b0;
  logic       nrst;
  logic       training, testing, ack, done, pc;
  logic       sample_req, sample_is_test, tr_fin, te_fin, busy;
  logic [2:0] sample_addr;
  logic [1:0] correct_count;

  logic       tr1, te1, ack1, done1, pc1;
  logic       req1, is_test1, tr_fin1, te_fin1, busy1;
  logic [0:0] addr1;
  logic [7:0] count1;

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dataset_sequencer #(.NUM_TRAIN(NTR), .NUM_TEST(NTE), .ADDR_W(3), .CNT_W(2)) dut (
    .clk(clk), .nrst(nrst), .training_hdc_model(training), .testing_hdc_model(testing),
    .sample_req(sample_req), .sample_addr(sample_addr), .sample_is_test(sample_is_test),
    .sample_ack(ack), .sample_done(done), .pred_correct(pc),
    .training_dataset_finished(tr_fin), .testing_dataset_finished(te_fin),
    .correct_count(correct_count), .busy(busy)
  );

  dataset_sequencer #(.NUM_TRAIN(1), .NUM_TEST(1), .ADDR_W(1), .CNT_W(8)) dut1 (
    .clk(clk), .nrst(nrst), .training_hdc_model(tr1), .testing_hdc_model(te1),
    .sample_req(req1), .sample_addr(addr1), .sample_is_test(is_test1),
    .sample_ack(ack1), .sample_done(done1), .pred_correct(pc1),
    .training_dataset_finished(tr_fin1), .testing_dataset_finished(te_fin1),
    .correct_count(count1), .busy(busy1)
  );

  // Full pass with a behavioural encoder; corr[i] is the prediction outcome of sample i.
  task automatic run_pass(input bit test, input int n, input bit [7:0] corr, input bit rnd);
    int idx = 0, fins = 0, wrongfin = 0, addr_err = 0, stab_err = 0, st_err = 0;
    int budget = 0, wait_ack = -1, dly = 0, exp_cnt = 0, extra = 0;
    bit acked = 0;
    logic [2:0] held = '0;
    for (int i = 0; i < n; i++) if (corr[i]) exp_cnt++;
    if (exp_cnt > 3) exp_cnt = 3;
    @(negedge clk);
    if (test) testing = 1'b1; else training = 1'b1;
    while (fins == 0 && budget < 500) begin
      @(negedge clk);
      budget++;
      ack = 1'b0; done = 1'b0; pc = 1'b0;
      if (budget == 1 && sample_req !== 1'b1) st_err++;
      if ((test ? tr_fin : te_fin) !== 1'b0) wrongfin++;
      if ((test ? te_fin : tr_fin) === 1'b1) fins++;
      if (sample_is_test !== test || busy !== 1'b1) st_err++;
      if (sample_req === 1'b1 && !acked) begin
        if (wait_ack < 0) begin
          if (sample_addr !== 3'(idx)) addr_err++;
          held = sample_addr;
          wait_ack = rnd ? int'($urandom_range(0, 3)) : 0;
        end else if (sample_addr !== held) stab_err++;
        if (wait_ack == 0) begin
          ack = 1'b1; acked = 1; wait_ack = -1;
          dly = rnd ? int'($urandom_range(1, 4)) : 3;
        end else wait_ack--;
      end else if (acked) begin
        if (sample_req !== 1'b0) stab_err++;
        dly--;
        if (dly == 0) begin
          done = 1'b1; pc = corr[idx]; idx++; acked = 0;
        end
      end
    end
    n_cmp++; if (idx !== n) begin n_fail++; $display("FAIL pass_samples: got %0d want %0d", idx, n); end
    n_cmp++; if (fins !== 1) begin n_fail++; $display("FAIL pass_fin: got %0d want 1", fins); end
    n_cmp++; if (addr_err !== 0) begin n_fail++; $display("FAIL pass_addr: got %0d errs want 0", addr_err); end
    n_cmp++; if (stab_err !== 0) begin n_fail++; $display("FAIL pass_hold: got %0d errs want 0", stab_err); end
    n_cmp++; if (st_err !== 0) begin n_fail++; $display("FAIL pass_status: got %0d errs want 0", st_err); end
    n_cmp++; if (wrongfin !== 0) begin n_fail++; $display("FAIL pass_wrongfin: got %0d want 0", wrongfin); end
    if (test) begin
      n_cmp++;
      if (correct_count !== 2'(exp_cnt)) begin
        n_fail++; $display("FAIL pass_count: got %0d want %0d", correct_count, exp_cnt);
      end
    end
    repeat (3) begin
      @(negedge clk);
      if (tr_fin !== 1'b0 || te_fin !== 1'b0 || busy !== 1'b1 || sample_req !== 1'b0) extra++;
    end
    n_cmp++; if (extra !== 0) begin n_fail++; $display("FAIL fin_hold: got %0d errs want 0", extra); end
    training = 1'b0; testing = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL busy_fall: got %b want 0", busy); end
    if (test) begin
      n_cmp++;
      if (correct_count !== 2'(exp_cnt)) begin
        n_fail++; $display("FAIL count_keep: got %0d want %0d", correct_count, exp_cnt);
      end
    end
  endtask

  // Serve k samples with immediate ack and done one cycle later; called at a negedge.
  task automatic serve(input int k, input bit corr);
    for (int s = 0; s < k; s++) begin
      int t = 0;
      while (sample_req !== 1'b1 && t < 20) begin @(negedge clk); t++; end
      n_cmp++; if (sample_req !== 1'b1) begin n_fail++; $display("FAIL serve_req: got %b want 1", sample_req); end
      ack = 1'b1; @(negedge clk); ack = 1'b0;
      done = 1'b1; pc = corr; @(negedge clk); done = 1'b0; pc = 1'b0;
    end
  endtask

  task automatic test_reset();
    nrst = 1'b0; training = 0; testing = 0; ack = 0; done = 0; pc = 0;
    tr1 = 0; te1 = 0; ack1 = 0; done1 = 0; pc1 = 0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sample_req, sample_is_test, tr_fin, te_fin, busy, sample_addr, correct_count} !== '0) begin
      n_fail++; $display("FAIL reset_state: got %b want 0",
        {sample_req, sample_is_test, tr_fin, te_fin, busy, sample_addr, correct_count});
    end
    nrst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_priority();
    training = 1'b1; testing = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({sample_req, sample_is_test, sample_addr} !== 5'b10_000) begin
      n_fail++; $display("FAIL priority: got %b want 10000", {sample_req, sample_is_test, sample_addr});
    end
    training = 1'b0; testing = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL priority_abort: got %b want 0", busy); end
  endtask

  task automatic test_ack_stall();
    int bad = 0;
    training = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      if (sample_req !== 1'b1 || sample_addr !== 3'd0) bad++;
      done = i[0];
      @(negedge clk);
      done = 1'b0;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL stall_hold: got %0d errs want 0", bad); end
    ack = 1'b1; done = 1'b1;
    @(negedge clk);
    ack = 1'b0; done = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({sample_req, sample_addr} !== 4'b0_000) begin
      n_fail++; $display("FAIL stall_done_ignored: got %b want 0000", {sample_req, sample_addr});
    end
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    n_cmp++;
    if ({sample_req, sample_addr} !== 4'b1_001) begin
      n_fail++; $display("FAIL stall_next: got %b want 1001", {sample_req, sample_addr});
    end
    training = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL stall_abort: got %b want 0", busy); end
  endtask

  task automatic test_abort();
    int bad = 0;
    training = 1'b1;
    @(negedge clk);
    serve(2, 1'b0);
    n_cmp++; if (sample_addr !== 3'd2) begin n_fail++; $display("FAIL abort_idx: got %0d want 2", sample_addr); end
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    training = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy !== 1'b0 || sample_req !== 1'b0 || tr_fin !== 1'b0 || te_fin !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL abort_train: got %0d errs want 0", bad); end
    testing = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({sample_req, sample_is_test, sample_addr} !== 5'b11_000) begin
      n_fail++; $display("FAIL abort_restart: got %b want 11000", {sample_req, sample_is_test, sample_addr});
    end
    serve(2, 1'b1);
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    testing = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, te_fin, correct_count} !== 4'b0_0_10) begin
      n_fail++; $display("FAIL abort_test: got %b want 0010", {busy, te_fin, correct_count});
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    testing = 1'b1;
    @(negedge clk);
    serve(1, 1'b1);
    ack = 1'b1; @(negedge clk); ack = 1'b0;
    #1 nrst = 1'b0;
    #1;
    n_cmp++;
    if ({sample_req, sample_is_test, tr_fin, te_fin, busy, sample_addr, correct_count} !== '0) begin
      n_fail++; $display("FAIL reset_mid: got %b want 0",
        {sample_req, sample_is_test, tr_fin, te_fin, busy, sample_addr, correct_count});
    end
    testing = 1'b0;
    @(negedge clk);
    nrst = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (tr_fin !== 1'b0 || te_fin !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL reset_after: got %0d errs want 0", bad); end
  endtask

  task automatic test_single(input bit test);
    int reqs = 0, fins = 0, bad = 0;
    bit acked = 0;
    if (test) te1 = 1'b1; else tr1 = 1'b1;
    repeat (12) begin
      @(negedge clk);
      ack1 = 1'b0; done1 = 1'b0; pc1 = 1'b0;
      if ((test ? te_fin1 : tr_fin1) === 1'b1) fins++;
      if (addr1 !== 1'b0 || is_test1 !== test) bad++;
      if (req1 === 1'b1 && !acked) begin
        reqs++; ack1 = 1'b1; acked = 1;
      end else if (acked) begin
        done1 = 1'b1; pc1 = 1'b1; acked = 0;
      end
    end
    n_cmp++; if (reqs !== 1) begin n_fail++; $display("FAIL single_reqs: got %0d want 1", reqs); end
    n_cmp++; if (fins !== 1) begin n_fail++; $display("FAIL single_fin: got %0d want 1", fins); end
    n_cmp++; if (bad !== 0) begin n_fail++; $display("FAIL single_addr: got %0d errs want 0", bad); end
    if (test) begin
      n_cmp++; if (count1 !== 8'd1) begin n_fail++; $display("FAIL single_count: got %0d want 1", count1); end
    end
    tr1 = 1'b0; te1 = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    run_pass(1'b0, NTR, 8'h00, 1'b0);
    run_pass(1'b1, NTE, 8'b01101, 1'b0);
    run_pass(1'b1, NTE, 8'b11111, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bit t;
      t = 1'($urandom_range(0, 1));
      run_pass(t, t ? NTE : NTR, 8'($urandom), 1'b1);
    end
    test_priority();
    test_ack_stall();
    test_abort();
    test_reset_mid();
    run_pass(1'b0, NTR, 8'h00, 1'b1);
    test_single(1'b0);
    test_single(1'b1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
